// File: rtl/microseq_stack_if.sv
// microseq_stack_if -- microword/condition bus between the microcode ROM side
// and the microprogram sequencer.
//   master: drives HOLD, OP, CSEL, CPOL, BR_ADDR, MAP_ADDR, COND;
//           observes CAR, STK_FULL, STK_EMPTY, CNT_ZERO, ERR.
//   slave : the sequencer (microseq_stack).
interface microseq_stack_if #(
  parameter int unsigned AW    = 11,
  parameter int unsigned NCOND = 16
) ();
  localparam int unsigned CW = (NCOND > 1) ? $clog2(NCOND) : 1;

  logic             HOLD;
  logic [2:0]       OP;
  logic [CW-1:0]    CSEL;
  logic             CPOL;
  logic [AW-1:0]    BR_ADDR;
  logic [AW-1:0]    MAP_ADDR;
  logic [NCOND-1:0] COND;
  logic [AW-1:0]    CAR;
  logic             STK_FULL;
  logic             STK_EMPTY;
  logic             CNT_ZERO;
  logic             ERR;

  modport master (
    output HOLD, OP, CSEL, CPOL, BR_ADDR, MAP_ADDR, COND,
    input  CAR, STK_FULL, STK_EMPTY, CNT_ZERO, ERR
  );

  modport slave (
    input  HOLD, OP, CSEL, CPOL, BR_ADDR, MAP_ADDR, COND,
    output CAR, STK_FULL, STK_EMPTY, CNT_ZERO, ERR
  );
endinterface

// File: rtl/microseq_stack.sv
// microseq_stack -- microprogram sequencer producing the control address
// register (CAR) for the microcode ROM. Supports conditional jump, opcode
// mapping, subroutine call/return via a LIFO return-address stack, a loop
// counter, and restart.
//
// Ports:
//   CLK  - system clock, rising edge
//   RST  - asynchronous active-high reset
//   bus  - microseq_stack_if.slave: HOLD/OP/CSEL/CPOL/BR_ADDR/MAP_ADDR/COND in,
//          CAR/STK_FULL/STK_EMPTY/CNT_ZERO/ERR out
//
// Build option: define MSEQ_ERR_TRAP_EN to vector CAR to TRAP_ADDR on stack
// overflow/underflow instead of falling through to CAR+1.
module microseq_stack #(
  parameter int unsigned   AW          = 11,
  parameter int unsigned   STACK_DEPTH = 4,
  parameter int unsigned   NCOND       = 16,
  parameter int unsigned   CNT_W       = 8,
  parameter logic [AW-1:0] TRAP_ADDR   = 11'h7F0
) (
  input  logic               CLK,
  input  logic               RST,
  microseq_stack_if.slave    bus
);

  localparam int unsigned SPW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_CONT    = 3'b000,
    OP_JUMP    = 3'b001,
    OP_MAP     = 3'b010,
    OP_CALL    = 3'b011,
    OP_RET     = 3'b100,
    OP_LDCNT   = 3'b101,
    OP_LOOP    = 3'b110,
    OP_RESTART = 3'b111
  } op_e;

  logic [AW-1:0]    car_q, car_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [AW-1:0]    stk_q [STACK_DEPTH];

  op_e              op;
  logic             cond_raw;
  logic             c;
  logic             full, empty;
  logic             push;
  logic [AW-1:0]    inc;
  logic [AW-1:0]    fault_car;
  logic [IW-1:0]    wr_idx, top_idx;

  assign op    = op_e'(bus.OP);
  assign inc   = car_q + 1'b1;
  assign full  = (sp_q == SPW'(STACK_DEPTH));
  assign empty = (sp_q == '0);

  // Push goes to slot SP, the top of stack lives at SP-1; both are only
  // used when in range (not full / not empty respectively).
  assign wr_idx  = IW'(sp_q);
  assign top_idx = IW'(sp_q - 1'b1);

`ifdef MSEQ_ERR_TRAP_EN
  assign fault_car = TRAP_ADDR;
`else
  assign fault_car = inc;
`endif

  // Out-of-range select reads as a constant 0 before polarity is applied.
  always_comb begin
    cond_raw = 1'b0;
    if (32'(bus.CSEL) < NCOND) cond_raw = bus.COND[bus.CSEL];
  end
  assign c = cond_raw ^ bus.CPOL;

  always_comb begin
    car_d = car_q;
    sp_d  = sp_q;
    cnt_d = cnt_q;
    err_d = err_q;
    push  = 1'b0;
    if (!bus.HOLD) begin
      case (op)
        OP_CONT: car_d = inc;
        OP_JUMP: car_d = c ? bus.BR_ADDR : inc;
        OP_MAP:  car_d = bus.MAP_ADDR;
        OP_CALL: begin
          if (!c) begin
            car_d = inc;
          end else if (full) begin
            car_d = fault_car;
            err_d = 1'b1;
          end else begin
            push  = 1'b1;
            sp_d  = sp_q + 1'b1;
            car_d = bus.BR_ADDR;
          end
        end
        OP_RET: begin
          if (!c) begin
            car_d = inc;
          end else if (empty) begin
            car_d = fault_car;
            err_d = 1'b1;
          end else begin
            sp_d  = sp_q - 1'b1;
            car_d = stk_q[top_idx];
          end
        end
        OP_LDCNT: begin
          cnt_d = bus.BR_ADDR[CNT_W-1:0];
          car_d = inc;
        end
        OP_LOOP: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            car_d = bus.BR_ADDR;
          end else begin
            car_d = inc;
          end
        end
        OP_RESTART: begin
          car_d = '0;
          sp_d  = '0;
          cnt_d = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      car_q <= '0;
      sp_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      for (int unsigned i = 0; i < STACK_DEPTH; i++) stk_q[i] <= '0;
    end else begin
      car_q <= car_d;
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      if (push) stk_q[wr_idx] <= inc;
    end
  end

  assign bus.CAR       = car_q;
  assign bus.STK_FULL  = full;
  assign bus.STK_EMPTY = empty;
  assign bus.CNT_ZERO  = (cnt_q == '0);
  assign bus.ERR       = err_q;

endmodule

// File: tb/tb_microseq_stack.sv
// tb_microseq_stack -- directed stimulus with a queue-based scoreboard for
// microseq_stack (AW=11, STACK_DEPTH=4, NCOND=16, CNT_W=8).
// Driver pushes the hand-computed CAR and flags {FULL,EMPTY,CNT_ZERO,ERR}
// for each issued operation; the monitor pops and compares after each
// rising edge, or immediately on an asynchronous reset check.
module tb_microseq_stack;

`ifdef MSEQ_ERR_TRAP_EN
  localparam logic [10:0] OVF_CAR = 11'h7F0;
  localparam logic [10:0] UDF_CAR = 11'h7F0;
`else
  localparam logic [10:0] OVF_CAR = 11'h101;
  localparam logic [10:0] UDF_CAR = 11'h002;
`endif

  localparam logic [2:0] CONT = 3'd0, JUMP = 3'd1, MAP = 3'd2, CALL = 3'd3,
                         RET = 3'd4, LDCNT = 3'd5, LOOP = 3'd6, RESTART = 3'd7;

  typedef struct {
    string       nm;
    logic [10:0] car;
    logic [3:0]  flg;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  exp_t exp_q[$];
  event chk_ev;
  int   checks = 0;
  int   failures = 0;
  logic [10:0] map_v = 11'h155;

  microseq_stack_if #(.AW(11), .NCOND(16)) sb ();

  microseq_stack #(
    .AW(11), .STACK_DEPTH(4), .NCOND(16), .CNT_W(8), .TRAP_ADDR(11'h7F0)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(sb)
  );

  always #5 CLK = ~CLK;

  // Monitor
  initial begin
    exp_t e;
    logic [3:0] act;
    forever begin
      @(posedge CLK or chk_ev);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = {sb.STK_FULL, sb.STK_EMPTY, sb.CNT_ZERO, sb.ERR};
        checks++;
        if (sb.CAR !== e.car || act !== e.flg) begin
          failures++;
          $display("FAIL %s: CAR=%h flags(F,E,Z,ERR)=%b expected CAR=%h flags=%b",
                   e.nm, sb.CAR, act, e.car, e.flg);
        end
      end
    end
  end

  task automatic push_exp(input string nm, input logic [10:0] ecar, input logic [3:0] eflg);
    exp_t e;
    e.nm = nm; e.car = ecar; e.flg = eflg;
    exp_q.push_back(e);
  endtask

  task automatic step(input string nm, input logic [2:0] op, input logic [3:0] csel,
                      input logic cpol, input logic [10:0] br, input logic hold,
                      input logic [10:0] ecar, input logic [3:0] eflg);
    @(negedge CLK);
    sb.OP = op; sb.CSEL = csel; sb.CPOL = cpol; sb.BR_ADDR = br;
    sb.MAP_ADDR = map_v; sb.HOLD = hold;
    push_exp(nm, ecar, eflg);
    @(posedge CLK);
  endtask

  // Async reset: checked while RST is still high, before any clock edge.
  task automatic reset_check(input string nm);
    @(negedge CLK);
    sb.HOLD = 1'b1;
    #1;
    RST = 1'b1;
    push_exp(nm, 11'h000, 4'b0110);
    -> chk_ev;
    #2;
    RST = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  initial begin
    sb.HOLD = 1'b1; sb.OP = CONT; sb.CSEL = '0; sb.CPOL = 1'b0;
    sb.BR_ADDR = '0; sb.MAP_ADDR = map_v; sb.COND = 16'h0005;

    reset_check("reset");
    step("cont1", CONT, 0, 0, 11'h000, 0, 11'h001, 4'b0110);
    step("cont2", CONT, 0, 0, 11'h000, 0, 11'h002, 4'b0110);
    step("cont3", CONT, 0, 0, 11'h000, 0, 11'h003, 4'b0110);
    for (int i = 0; i < 4; i++)
      step("hold_call", CALL, 0, 0, 11'h100, 1, 11'h003, 4'b0110);
    step("cont_after_hold", CONT, 0, 0, 11'h000, 0, 11'h004, 4'b0110);
    reset_check("mid_reset");

    step("jmp_to5", JUMP, 0, 0, 11'h005, 0, 11'h005, 4'b0110);
    step("jmp_c2_p0", JUMP, 2, 0, 11'h040, 0, 11'h040, 4'b0110);
    step("jmp_to5b", JUMP, 0, 0, 11'h005, 0, 11'h005, 4'b0110);
    step("jmp_c2_p1", JUMP, 2, 1, 11'h040, 0, 11'h006, 4'b0110);
    step("jmp_c1_p0", JUMP, 1, 0, 11'h040, 0, 11'h007, 4'b0110);
    step("jmp_c1_p1", JUMP, 1, 1, 11'h040, 0, 11'h040, 4'b0110);
    step("jmp_c15_p0", JUMP, 15, 0, 11'h200, 0, 11'h041, 4'b0110);
    map_v = 11'h010;
    step("map", MAP, 1, 0, 11'h3FF, 0, 11'h010, 4'b0110);

    step("call1", CALL, 0, 0, 11'h100, 0, 11'h100, 4'b0010);
    step("call2", CALL, 0, 0, 11'h200, 0, 11'h200, 4'b0010);
    step("ret2", RET, 0, 0, 11'h000, 0, 11'h101, 4'b0010);
    step("ret1", RET, 0, 0, 11'h000, 0, 11'h011, 4'b0110);
    step("call_nc", CALL, 1, 0, 11'h300, 0, 11'h012, 4'b0110);
    step("ret_nc_empty", RET, 1, 0, 11'h000, 0, 11'h013, 4'b0110);

    step("ldcnt3", LDCNT, 0, 0, 11'h703, 0, 11'h014, 4'b0100);
    step("loop_a", LOOP, 1, 0, 11'h020, 0, 11'h020, 4'b0100);
    step("loop_b", LOOP, 1, 0, 11'h020, 0, 11'h020, 4'b0100);
    step("loop_c", LOOP, 1, 0, 11'h020, 0, 11'h020, 4'b0110);
    step("loop_exit", LOOP, 0, 0, 11'h020, 0, 11'h021, 4'b0110);

    step("call_pre_rst", CALL, 0, 0, 11'h050, 0, 11'h050, 4'b0010);
    step("ldcnt5", LDCNT, 0, 0, 11'h005, 0, 11'h051, 4'b0000);
    step("restart", RESTART, 0, 0, 11'h123, 0, 11'h000, 4'b0110);

    step("ovf_call1", CALL, 0, 0, 11'h100, 0, 11'h100, 4'b0010);
    step("ovf_call2", CALL, 0, 0, 11'h100, 0, 11'h100, 4'b0010);
    step("ovf_call3", CALL, 0, 0, 11'h100, 0, 11'h100, 4'b0010);
    step("ovf_call4", CALL, 0, 0, 11'h100, 0, 11'h100, 4'b1010);
    step("ovf_call5", CALL, 0, 0, 11'h100, 0, OVF_CAR, 4'b1011);
    step("hold_ret_a", RET, 0, 0, 11'h000, 1, OVF_CAR, 4'b1011);
    step("hold_ret_b", RET, 0, 0, 11'h000, 1, OVF_CAR, 4'b1011);
    step("pop4", RET, 0, 0, 11'h000, 0, 11'h101, 4'b0011);
    step("pop3", RET, 0, 0, 11'h000, 0, 11'h101, 4'b0011);
    step("pop2", RET, 0, 0, 11'h000, 0, 11'h101, 4'b0011);
    step("pop1", RET, 0, 0, 11'h000, 0, 11'h001, 4'b0111);
    step("udf_ret", RET, 0, 0, 11'h000, 0, UDF_CAR, 4'b0111);

    step("jmp_7ff", JUMP, 0, 0, 11'h7FF, 0, 11'h7FF, 4'b0111);
    step("wrap", CONT, 0, 0, 11'h000, 0, 11'h000, 4'b0111);
    reset_check("final_reset");

    repeat (2) @(posedge CLK);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/microseq_stack.md
Name: microseq_stack

Overview:
- Parametrised next-generation microprogram sequencer. Generates the control address register (CAR) that drives the microcode ROM.
- Adds a subroutine call/return stack, a loop counter, a wide condition-select mux with polarity, and opcode mapping.
- Sits between the microcode ROM output fields and the ROM address input. Condition flags come from the CPU status registers.

Parameters:
- AW, 11, CAR/address width in bits.
- STACK_DEPTH, 4, number of return-address entries (≥1).
- NCOND, 16, number of condition inputs. Select width is CW = $clog2(NCOND).
- CNT_W, 8, loop counter width (≤ AW).
- TRAP_ADDR, 11'h7F0, trap vector (used only with optional feature).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- HOLD  in  1  stall: when 1, all state is frozen.
- OP  in  3  next-address operation from the microword.
- CSEL  in  CW  condition select index.
- CPOL  in  1  condition polarity: 1 inverts the selected condition.
- BR_ADDR  in  AW  branch target, or loop count in its low CNT_W bits.
- MAP_ADDR  in  AW  opcode-mapped address, e.g. {0, IR[15:9], 000}.
- COND  in  NCOND  condition vector. Bit 0 is tied to 1 externally (always-true).
- CAR  out  AW  current microcode address.
- STK_FULL  out  1  stack holds STACK_DEPTH entries.
- STK_EMPTY  out  1  stack holds 0 entries.
- CNT_ZERO  out  1  loop counter == 0.
- ERR  out  1  sticky stack overflow/underflow flag.

Behaviour:
- Reset (async, RST=1):
  - CAR=0, stack pointer SP=0, all stack entries=0, CNT=0, ERR=0.
  - Outputs: STK_EMPTY=1, STK_FULL=0, CNT_ZERO=1.
  - Reset mid-operation discards any pending call, return or loop state.
- Registered update: all state updates on the rising CLK edge and only when HOLD=0. CAR is therefore valid one cycle after OP is presented.
- Conditions:
  - c = COND[CSEL] ^ CPOL.
  - If CSEL ≥ NCOND, c = 0 ^ CPOL.
- Incrementer: INC = CAR+1 modulo 2^AW. From all-ones, CAR wraps to 0 with no error.
- OP encoding:
  - 000 CONT: CAR←INC.
  - 001 JUMP: CAR←c ? BR_ADDR : INC.
  - 010 MAP: CAR←MAP_ADDR, unconditional.
  - 011 CALL: if c and not full, push INC, SP+1, CAR←BR_ADDR. If not c, CAR←INC.
  - 100 RET: if c and not empty, CAR←top entry, SP−1. If not c, CAR←INC.
  - 101 LDCNT: CNT←BR_ADDR[CNT_W-1:0], CAR←INC.
  - 110 LOOP:
    - If CNT≠0: CNT←CNT−1 and CAR←BR_ADDR.
    - If CNT=0: CAR←INC, CNT unchanged.
    - LOOP ignores c.
  - 111 RESTART: CAR←0, SP←0, CNT←0. ERR is unchanged.
- Boundary conditions:
  - CALL with c=1 when full is an overflow: no push, SP unchanged, CAR←INC, ERR←1.
  - RET with c=1 when empty is an underflow: SP stays 0, CAR←INC, ERR←1.
  - ERR clears only on RST.
- Stack is LIFO; SP ranges 0..STACK_DEPTH. A CALL to the same routine nests correctly up to STACK_DEPTH levels.
- HOLD=1 with any OP: CAR, SP, CNT and ERR all hold. No error is flagged while held.
- Status outputs STK_FULL, STK_EMPTY and CNT_ZERO are combinational from registered state.

Optional Feature:
- Macro: MSEQ_ERR_TRAP_EN.
- Defined: on overflow or underflow, CAR←TRAP_ADDR instead of INC, and ERR is set as usual.
- Undefined: CAR←INC as above, and TRAP_ADDR is unused.

Test Plan:
- Reset, then CONT ×3 with HOLD=0 → CAR 0,1,2,3. Assert RST mid-sequence → CAR=0 immediately, STK_EMPTY=1.
- Branch on conditions: CAR=5, JUMP with CSEL=2, COND[2]=1, CPOL=0, BR_ADDR=0x40 → CAR=0x40. Same with CPOL=1 → CAR=6.
- Nested calls (STACK_DEPTH=4):
  - CALL 0x100 at CAR=0x10, then CALL 0x200 at CAR=0x100 → CAR=0x200.
  - RET → CAR=0x101. RET → CAR=0x11, STK_EMPTY=1.
- Loop counter: LDCNT with BR_ADDR=3, then repeated LOOP to 0x20 → branches taken 3 times, then CAR=INC, CNT_ZERO=1.
- Stack errors:
  - 5 CALLs → 5th gives CAR=INC, ERR=1, STK_FULL=1.
  - RET on empty → ERR=1.
  - With MSEQ_ERR_TRAP_EN defined → CAR=0x7F0 in both cases.
- Wrap and hold: CAR=0x7FF with CONT → CAR=0x000. HOLD=1 for 4 cycles with OP=CALL → CAR, SP and ERR unchanged.
